// File: rtl/fir_block_sequencer.sv
// fir_block_sequencer: runs one block of samples through an external moving-sum FIR.
// Clears the delay line, feeds block_len samples plus TAP_SIZE-1 zeros, and forwards every output.
`default_nettype none

module fir_block_sequencer #(
    parameter int TAP_SIZE = 4,
    parameter int WIDTH    = 16,
    parameter int LEN_W    = 12,
    localparam int OUT_W   = WIDTH + $clog2(TAP_SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] block_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             fir_reset,
    output logic             fir_in_valid,
    output logic [WIDTH-1:0] fir_in,
    input  logic             fir_out_valid,
    input  logic [OUT_W-1:0] fir_out,
    output logic             m_valid,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last
);

    localparam int CNT_W = LEN_W + 1;
    localparam int FL_W  = $clog2(TAP_SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [FL_W-1:0]   flush_cnt;

    logic              handshake;
    logic              last_in;
    logic              out_hit;
    logic [CNT_W-1:0]  total_out;

    assign total_out = {1'b0, len} + CNT_W'(TAP_SIZE - 1);
    assign handshake = (state == S_FEED) && s_valid;
    assign last_in   = handshake && ((in_cnt + CNT_W'(1)) == {1'b0, len});
    // FIR outputs are only forwarded while a block is in flight.
    assign out_hit   = busy && fir_out_valid;

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        s_ready      = 1'b0;
        fir_in_valid = 1'b0;
        fir_in       = '0;
        // The delay line is held clear for as long as reset is asserted.
        fir_reset    = ~reset;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (block_len != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                busy      = 1'b1;
                fir_reset = 1'b1;
                state_nxt = S_FEED;
            end
            S_FEED: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    fir_in_valid = 1'b1;
                    fir_in       = s_data;
                end
                if (last_in) begin
                    state_nxt = (TAP_SIZE > 1) ? S_FLUSH : S_DRAIN;
                end
            end
            S_FLUSH: begin
                busy         = 1'b1;
                fir_in_valid = 1'b1;
                if (flush_cnt == FL_W'(1)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (m_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign err = start && busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len       <= '0;
            in_cnt    <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == S_IDLE && start && block_len != '0) begin
                len    <= block_len;
                in_cnt <= '0;
            end else if (handshake) begin
                in_cnt <= in_cnt + CNT_W'(1);
            end

            if (last_in) begin
                flush_cnt <= FL_W'(TAP_SIZE - 1);
            end else if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt - FL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_cnt <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            m_valid <= out_hit;
            m_data  <= out_hit ? fir_out : '0;
            m_last  <= out_hit && ((out_cnt + CNT_W'(1)) == total_out);
            if (state == S_IDLE) begin
                out_cnt <= '0;
            end else if (out_hit) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_block_sequencer.sv
// tb_fir_block_sequencer: directed bench with a 4-tap moving-sum FIR model (1-cycle latency).
`default_nettype none

module tb_fir_block_sequencer;

    localparam int TAP_SIZE = 4;
    localparam int WIDTH    = 16;
    localparam int LEN_W    = 12;
    localparam int OUT_W    = WIDTH + $clog2(TAP_SIZE);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] block_len = '0;
    logic             busy, done, err;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             fir_reset, fir_in_valid;
    logic [WIDTH-1:0] fir_in;
    logic             fir_out_valid;
    logic [OUT_W-1:0] fir_out;
    logic             m_valid;
    logic [OUT_W-1:0] m_data;
    logic             m_last;

    fir_block_sequencer #(
        .TAP_SIZE(TAP_SIZE), .WIDTH(WIDTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .block_len(block_len),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_reset(fir_reset), .fir_in_valid(fir_in_valid), .fir_in(fir_in),
        .fir_out_valid(fir_out_valid), .fir_out(fir_out),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Reference moving-sum FIR standing in for the datapath.
    logic [WIDTH-1:0] dl [0:TAP_SIZE-2];
    always @(posedge clk) begin
        if (fir_reset) begin
            for (int i = 0; i < TAP_SIZE - 1; i++) dl[i] <= '0;
            fir_out_valid <= 1'b0;
            fir_out       <= '0;
        end else begin
            fir_out_valid <= fir_in_valid;
            if (fir_in_valid) begin
                fir_out <= OUT_W'(fir_in) + OUT_W'(dl[0]) + OUT_W'(dl[1]) + OUT_W'(dl[2]);
                dl[0] <= fir_in;
                for (int i = 1; i < TAP_SIZE - 1; i++) dl[i] <= dl[i-1];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Observation log, sampled mid-cycle.
    int cyc = 0;
    int mq[$];
    int lq[$];
    int fin_q[$];
    int hs_cnt, done_cnt, err_cnt, fr_cnt, last_cyc, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_log();
        mq.delete(); lq.delete(); fin_q.delete();
        hs_cnt = 0; done_cnt = 0; err_cnt = 0; fr_cnt = 0;
        last_cyc = -100; done_cyc = -200;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (m_valid) begin
                    mq.push_back(int'(m_data));
                    lq.push_back(int'(m_last));
                    if (m_last) last_cyc = cyc;
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (err) err_cnt++;
                if (fir_reset) fr_cnt++;
                if (s_valid && s_ready) hs_cnt++;
                if (fir_in_valid) fin_q.push_back(int'(fir_in));
            end
        end
    end

    int samp[$];

    task automatic wait_hs(input bit pulse);
        bit got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (pulse && k == 0) check("err_pulse", err, 1);
            if (s_ready) got = 1'b1;
            @(posedge clk); #1;
            if (pulse) begin start = 1'b0; pulse = 1'b0; end
        end
        if (!got) check("handshake_timeout", 0, 1);
    endtask

    task automatic run_block(input int len, input int gap, input int pulse_at);
        clear_log();
        start = 1'b1; block_len = LEN_W'(len);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < samp.size(); i++) begin
            s_valid = 1'b1; s_data = WIDTH'(samp[i]);
            if (i == pulse_at) begin start = 1'b1; block_len = LEN_W'(9); end
            wait_hs(i == pulse_at);
            s_valid = 1'b0; s_data = '0;
            if (i < samp.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_fir_in_valid", fir_in_valid, 0);
                    check("gap_busy", busy, 1);
                    @(posedge clk); #1;
                end
            end
        end
        for (int k = 0; k < 200 && done_cnt == 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_block(input int exp[$], input int fin[$], input int nhs);
        check("out_count", mq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < mq.size(); i++) begin
            check($sformatf("m_data[%0d]", i), mq[i], exp[i]);
            check($sformatf("m_last[%0d]", i), lq[i], (i == exp.size() - 1) ? 1 : 0);
        end
        check("fir_in_count", fin_q.size(), fin.size());
        for (int i = 0; i < fin.size() && i < fin_q.size(); i++)
            check($sformatf("fir_in[%0d]", i), fin_q[i], fin[i]);
        check("handshakes", hs_cnt, nhs);
        check("done_count", done_cnt, 1);
        check("done_after_last", done_cyc - last_cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_fir_in_valid", fir_in_valid, 0);
        check("rst_fir_in", fir_in, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_fir_reset", fir_reset, 1);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_fir_reset", fir_reset, 0);

        // 1: back-to-back samples
        samp = {1, 2, 3};
        run_block(3, 0, -1);
        check_block({1, 3, 6, 6, 5, 3}, {1, 2, 3, 0, 0, 0}, 3);
        check("t1_err", err_cnt, 0);

        // 2: two-cycle gaps between samples
        run_block(3, 2, -1);
        check_block({1, 3, 6, 6, 5, 3}, {1, 2, 3, 0, 0, 0}, 3);

        // 3: full-scale samples, no truncation
        samp = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_block(4, 0, -1);
        check_block({65535, 131070, 196605, 262140, 196605, 131070, 65535},
                    {65535, 65535, 65535, 65535, 0, 0, 0}, 4);

        // 4: zero-length block
        clear_log();
        start = 1'b1; block_len = '0;
        @(negedge clk);
        check("z_busy_idle", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("z_done", done, 1);
        check("z_busy_done", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        check("z_done_count", done_cnt, 1);
        check("z_fir_reset_cycles", fr_cnt, 0);
        check("z_fir_in_valid", fin_q.size(), 0);
        check("z_m_valid", mq.size(), 0);

        // 5: reset in the middle of a block
        clear_log();
        samp = {10, 20, 30, 40, 50};
        start = 1'b1; block_len = LEN_W'(5);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = WIDTH'(samp[i]);
            wait_hs(1'b0);
        end
        s_valid = 1'b0; s_data = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_s_ready", s_ready, 0);
        check("mr_fir_in_valid", fir_in_valid, 0);
        check("mr_m_valid", m_valid, 0);
        check("mr_m_data", m_data, 0);
        check("mr_fir_reset", fir_reset, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mr_no_done", done_cnt, 0);
        samp = {7};
        run_block(1, 0, -1);
        check_block({7, 7, 7, 7}, {7, 0, 0, 0}, 1);

        // 6: start while busy
        samp = {1, 2, 3};
        run_block(3, 0, 1);
        check_block({1, 3, 6, 6, 5, 3}, {1, 2, 3, 0, 0, 0}, 3);
        check("busy_err_count", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_block_sequencer.md
Name: fir_block_sequencer

Overview:
Sequences one block of samples through the moving-sum FIR datapath (firTap: TAP_SIZE taps, WIDTH-bit input, WIDTH+clog2(TAP_SIZE)-bit output). On start it clears the FIR delay line. It then accepts block_len samples through a valid/ready handshake and appends TAP_SIZE-1 zero samples to flush the tail. It forwards all block_len+TAP_SIZE-1 full-convolution outputs, marks the last one, and pulses done.

Parameters:
TAP_SIZE, 4, number of FIR taps; must match the connected datapath.
WIDTH, 16, sample width in bits.
LEN_W, 12, width of block_len.
OUT_W, WIDTH+$clog2(TAP_SIZE), FIR output width (derived, not overridable).

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a block; sampled only in IDLE
block_len  in  LEN_W  input sample count, captured on the accepted start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at block completion
err  out  1  one-cycle pulse when start is asserted while busy
s_valid  in  1  upstream sample valid
s_ready  out  1  sequencer can accept a sample
s_data  in  WIDTH  upstream sample
fir_reset  out  1  active-high clear to the FIR delay line
fir_in_valid  out  1  drives FIR in_valid
fir_in  out  WIDTH  drives FIR in
fir_out_valid  in  1  FIR out_valid
fir_out  in  OUT_W  FIR out
m_valid  out  1  output sample valid; no backpressure
m_data  out  OUT_W  output sample
m_last  out  1  high with m_valid on the final output of the block

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all counters 0. busy, done, err, s_ready, fir_in_valid, m_valid and m_last are 0; fir_in and m_data are 0; fir_reset is 1. fir_reset is forced high for the whole time reset is low.
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE: s_ready=0, fir_reset=0.
  - start=1 with block_len>0: capture len, go to CLEAR.
  - start=1 with block_len=0: go to DONE (no FIR activity, no outputs).
- CLEAR: exactly 1 cycle with fir_reset=1; then FEED.
- FEED: s_ready=1. On each handshake (s_valid and s_ready both high):
  - fir_in_valid=1 and fir_in=s_data in the same cycle (combinational pass-through, zero latency);
  - in_cnt increments.
  - The handshake on which in_cnt reaches len moves the FSM to FLUSH on the next edge.
  - No handshake in a cycle: fir_in_valid=0 and fir_in=0.
- FLUSH: s_ready=0, fir_in_valid=1, fir_in=0 for exactly TAP_SIZE-1 cycles (down-counter); then DRAIN.
- DRAIN and every earlier active state: each cycle with fir_out_valid=1 gives:
  - m_valid=1 and m_data=fir_out, registered, so 1 cycle after fir_out_valid;
  - out_cnt increments;
  - m_last=1 when out_cnt reaches len+TAP_SIZE-1.
  - The FSM moves to DONE on the cycle m_last is issued.
- The FIR must produce exactly one out_valid per in_valid, in order, with fixed latency. The sequencer does not depend on the latency value.
- fir_out_valid pulses in IDLE or DONE are ignored (no m_valid).
- DONE: done=1 for 1 cycle, busy=0; next state IDLE. A start arriving in the DONE cycle is ignored and does not raise err.
- busy=1 in CLEAR, FEED, FLUSH and DRAIN.
- err: a 1-cycle pulse when start=1 in CLEAR, FEED, FLUSH or DRAIN. The running block is unaffected.
- Counters are LEN_W+1 bits wide and cannot wrap; the maximum output count is 2^LEN_W-1+TAP_SIZE-1.
- Reset low mid-block: immediate return to reset values. The partial block is discarded and no done is issued. The next block starts with a cleared delay line (via CLEAR).

Test Plan:
1. TAP_SIZE=4, block_len=3, s_data 1,2,3 back-to-back with s_valid held high -> fir_in sequence 1,2,3,0,0,0; m_data 1,3,6,6,5,3; m_last only on the 6th output; done 1 cycle after it; exactly 3 handshakes.
2. Same data with s_valid low for 2 cycles between each sample -> identical m_data; fir_in_valid=0 during the gaps; busy held high throughout.
3. block_len=4, all samples 16'hFFFF -> m_data 65535, 131070, 196605, 262140, 196605, 131070, 65535; no truncation at OUT_W=18.
4. block_len=0 with start -> done pulse in the cycle after start; fir_reset, fir_in_valid and m_valid stay 0.
5. Start a block of 5 samples, then after 2 handshakes drive reset low for 1 cycle -> all outputs go to 0 immediately and no done is issued. A new block of 1 sample (value 7) then gives m_data 7,7,7,7 with m_last on the 4th output, proving the delay line was cleared.
6. start pulsed during FEED -> err pulse for 1 cycle; current block completes with the correct count; len is not re-captured.
